// File: rtl/up_counter_pkg.sv
// Shared encodings for the loadable up counter: FSM state and mode select values.
package up_counter_pkg;

  typedef enum logic {
    ST_COUNT = 1'b0,
    ST_DONE  = 1'b1
  } state_t;

  localparam logic MODE_AUTO    = 1'b0;
  localparam logic MODE_ONESHOT = 1'b1;

endpackage

// File: rtl/up_counter_modulo.sv
// Loadable up counter toward a programmable limit, with auto-reload or one-shot halt,
// a one-cycle terminal-count pulse and a sticky overflow flag.
//
// state    | meaning
// ---------+-------------------------------------------
// ST_COUNT | counting allowed on en
// ST_DONE  | one-shot reached limit; dout frozen, en ignored
module up_counter_modulo
  import up_counter_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             ld,
  input  logic [WIDTH-1:0] ldvalue,
  input  logic [WIDTH-1:0] limit,
  input  logic             oneshot,
  input  logic             ovf_clr,
  output logic [WIDTH-1:0] dout,
  output logic             tc,
  output logic             done,
  output logic             ovf
);

  state_t           state;
  state_t           state_nxt;
  logic [WIDTH-1:0] dout_nxt;
  logic             tc_nxt;
  logic             ovf_set;
  logic             at_limit;
  logic             all_ones;

  assign at_limit = (dout == limit);
  assign all_ones = &dout;
  assign done     = (state == ST_DONE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_COUNT;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    dout_nxt  = dout;
    tc_nxt    = 1'b0;
    ovf_set   = 1'b0;
    if (ld) begin
      dout_nxt  = ldvalue;
      state_nxt = ST_COUNT;
    end else if (en && (state == ST_COUNT)) begin
      if (at_limit) begin
        tc_nxt = 1'b1;
        if (oneshot == MODE_ONESHOT) begin
          state_nxt = ST_DONE;
        end else begin
          dout_nxt = '0;
          ovf_set  = 1'b1;
        end
      end else begin
        // count past all-ones (limit below dout) is a wrap as well, but not a terminal count
        dout_nxt = dout + WIDTH'(1);
        ovf_set  = all_ones;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      dout <= '0;
      tc   <= 1'b0;
      ovf  <= 1'b0;
    end else begin
      dout <= dout_nxt;
      tc   <= tc_nxt;
      ovf  <= ovf_set | (ovf & ~ovf_clr);
    end
  end

endmodule

// File: tb/tb_up_counter_modulo.sv
// Directed bench for up_counter_modulo (WIDTH=4) with a queue scoreboard fed by a reference model.
module tb_up_counter_modulo;

  logic       clk = 1'b0;
  logic       rst, en, ld, oneshot, ovf_clr;
  logic [3:0] ldvalue, limit;
  logic [3:0] dout;
  logic       tc, done, ovf;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [3:0] d;
    logic       t;
    logic       dn;
    logic       o;
  } exp_t;

  exp_t sb[$];

  logic [3:0] m_dout = 4'd0;
  logic       m_tc = 1'b0, m_done = 1'b0, m_ovf = 1'b0;

  up_counter_modulo #(.WIDTH(4)) dut (
    .clk(clk), .rst(rst), .en(en), .ld(ld), .ldvalue(ldvalue), .limit(limit),
    .oneshot(oneshot), .ovf_clr(ovf_clr), .dout(dout), .tc(tc), .done(done), .ovf(ovf)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference model: advance expected state from the inputs currently driven.
  task automatic model_step();
    logic o;
    if (rst) begin
      m_dout = 4'd0; m_tc = 1'b0; m_done = 1'b0; m_ovf = 1'b0;
    end else begin
      o    = m_ovf && !ovf_clr;
      m_tc = 1'b0;
      if (ld) begin
        m_dout = ldvalue;
        m_done = 1'b0;
      end else if (en && !m_done) begin
        if (m_dout == limit) begin
          m_tc = 1'b1;
          if (oneshot) m_done = 1'b1;
          else begin
            m_dout = 4'd0;
            o      = 1'b1;
          end
        end else if (m_dout == 4'hF) begin
          m_dout = 4'd0;
          o      = 1'b1;
        end else begin
          m_dout = m_dout + 4'd1;
        end
      end
      m_ovf = o;
    end
  endtask

  task automatic tick(input string tag);
    exp_t e;
    model_step();
    sb.push_back('{d: m_dout, t: m_tc, dn: m_done, o: m_ovf});
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      checks++; errors++;
      $error("FAIL %s scoreboard empty observed=0 expected=1", tag);
    end else begin
      e = sb.pop_front();
      chk({tag, "_dout"}, dout, e.d);
      chk({tag, "_tc"},   {3'b0, tc},   {3'b0, e.t});
      chk({tag, "_done"}, {3'b0, done}, {3'b0, e.dn});
      chk({tag, "_ovf"},  {3'b0, ovf},  {3'b0, e.o});
    end
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; ld = 1'b0; oneshot = 1'b0; ovf_clr = 1'b0;
    ldvalue = 4'd0; limit = 4'd9;
    #2;
    tick("reset");
    rst = 1'b0;

    // 1: some activity, then reset
    ld = 1'b1; ldvalue = 4'd5; tick("t1_ld");
    ld = 1'b0; en = 1'b1; tick("t1_cnt"); tick("t1_cnt");
    rst = 1'b1; tick("t1_rst");
    chk("t1_rst_dout", dout, 4'd0);
    chk("t1_rst_tc", {3'b0, tc}, 4'd0);
    chk("t1_rst_done", {3'b0, done}, 4'd0);
    chk("t1_rst_ovf", {3'b0, ovf}, 4'd0);
    rst = 1'b0;

    // 2: auto-reload, limit 9 from 0
    limit = 4'd9; oneshot = 1'b0; en = 1'b1;
    for (int i = 0; i < 9; i++) tick("t2_up");
    chk("t2_at9", dout, 4'd9);
    tick("t2_wrap");
    chk("t2_wrap_dout", dout, 4'd0);
    chk("t2_wrap_tc", {3'b0, tc}, 4'd1);
    chk("t2_wrap_ovf", {3'b0, ovf}, 4'd1);
    tick("t2_after");
    chk("t2_after_dout", dout, 4'd1);
    chk("t2_after_tc", {3'b0, tc}, 4'd0);
    tick("t2_after");

    // 3: one-shot to 5, then reload
    en = 1'b0; ovf_clr = 1'b1; tick("t3_clr");
    ovf_clr = 1'b0; ld = 1'b1; ldvalue = 4'd0; limit = 4'd5; oneshot = 1'b1; tick("t3_ld");
    ld = 1'b0; en = 1'b1;
    for (int i = 0; i < 6; i++) tick("t3_up");
    chk("t3_done", {3'b0, done}, 4'd1);
    chk("t3_hold", dout, 4'd5);
    tick("t3_frozen"); tick("t3_frozen");
    oneshot = 1'b0; tick("t3_modechg");
    chk("t3_modechg_dout", dout, 4'd5);
    ld = 1'b1; ldvalue = 4'd2; tick("t3_reload");
    chk("t3_reload_done", {3'b0, done}, 4'd0);
    ld = 1'b0; oneshot = 1'b1; tick("t3_resume");
    chk("t3_resume_dout", dout, 4'd3);

    // 4: ld beats en
    ld = 1'b1; en = 1'b1; ldvalue = 4'd7; tick("t4_ld_en");
    chk("t4_dout", dout, 4'd7);
    ld = 1'b0;

    // 5: rollover above limit, then match on next pass
    ld = 1'b1; ldvalue = 4'd14; limit = 4'd3; oneshot = 1'b0; tick("t5_ld");
    ld = 1'b0; en = 1'b1;
    tick("t5_15");
    tick("t5_roll");
    chk("t5_roll_tc", {3'b0, tc}, 4'd0);
    chk("t5_roll_ovf", {3'b0, ovf}, 4'd1);
    tick("t5_1"); tick("t5_2"); tick("t5_3");
    // 6: clear coinciding with a wrap keeps ovf set
    ovf_clr = 1'b1; tick("t6_clr_on_wrap");
    chk("t6_wrap_tc", {3'b0, tc}, 4'd1);
    chk("t6_wrap_ovf", {3'b0, ovf}, 4'd1);
    en = 1'b0; tick("t6_clr_quiet");
    chk("t6_quiet_ovf", {3'b0, ovf}, 4'd0);
    ovf_clr = 1'b0;

    // limit 0 in auto mode: parked at 0, tc every enabled cycle
    limit = 4'd0; en = 1'b1;
    tick("lim0"); tick("lim0"); tick("lim0");
    chk("lim0_tc", {3'b0, tc}, 4'd1);

    // rst with ld and en asserted
    rst = 1'b1; ld = 1'b1; ldvalue = 4'd9; tick("t6_rst_ld");
    chk("t6_rst_ld_dout", dout, 4'd0);
    rst = 1'b0; ld = 1'b0; en = 1'b0;
    tick("idle");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
